// File: rtl/lsu_sram_pkg.sv
// rtl/lsu_sram_pkg.sv - shared types, constants and helpers for the LSU-to-SRAM bridge
package lsu_sram_pkg;

    // Word address bits forwarded to the controller (halfword address LSB is always 0)
    localparam int SRAM_WORD_BITS = 17;

    typedef enum logic [1:0] {
        SzByte    = 2'b00,
        SzHalf    = 2'b01,
        SzWord    = 2'b10,
        SzIllegal = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } bridge_state_e;

    // Byte-lane enables for an access of the given size at the given byte offset
    function automatic logic [3:0] gen_bmask(size_e size, logic [1:0] addr_lo);
        case (size)
            SzByte:  return 4'b0001 << addr_lo;
            SzHalf:  return 4'b0011 << addr_lo;
            default: return 4'b1111;
        endcase
    endfunction

    // Halfwords must be even, words must be word-aligned, size 11 is never legal
    function automatic logic is_misaligned(size_e size, logic [1:0] addr_lo);
        case (size)
            SzByte:  return 1'b0;
            SzHalf:  return addr_lo[0];
            SzWord:  return addr_lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_sram_align.sv
// rtl/lsu_sram_align.sv - store lane steering/mask and load extract/extend
module lsu_sram_align
    import lsu_sram_pkg::*;
(
    input  size_e       size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] ld_word_i,
    input  logic        unsigned_i,
    output logic [31:0] st_lanes_o,
    output logic [3:0]  bmask_o,
    output logic [31:0] ld_data_o
);

    logic [31:0] ld_shifted;

    assign bmask_o    = gen_bmask(size_i, addr_lo_i);
    assign ld_shifted = ld_word_i >> {addr_lo_i, 3'b000};

    // Replicate store data across lanes; move the addressed load lane to bit 0 and extend it
    always_comb begin
        st_lanes_o = st_data_i;
        ld_data_o  = ld_word_i;
        case (size_i)
            SzByte: begin
                st_lanes_o = {4{st_data_i[7:0]}};
                ld_data_o  = unsigned_i ? {24'd0, ld_shifted[7:0]}
                                        : {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            end
            SzHalf: begin
                st_lanes_o = {2{st_data_i[15:0]}};
                ld_data_o  = unsigned_i ? {16'd0, ld_shifted[15:0]}
                                        : {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            end
            default: begin
                st_lanes_o = st_data_i;
                ld_data_o  = ld_word_i;
            end
        endcase
    end

endmodule

// File: rtl/lsu_sram_bridge.sv
// rtl/lsu_sram_bridge.sv - single-outstanding CPU load/store to SRAM controller bridge (option: LSU_SRAM_TIMEOUT_EN)
module lsu_sram_bridge
    import lsu_sram_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic        o_ready,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_rdata,
    output logic [17:0] o_ADDR,
    output logic [31:0] o_WDATA,
    output logic [3:0]  o_BMASK,
    output logic        o_WREN,
    output logic        o_RDEN,
    input  logic [31:0] i_RDATA,
    input  logic        i_ACK
);

    bridge_state_e state_q;
    logic          we_q;
    logic [1:0]    addr_lo_q;
    size_e         size_q;
    logic          unsigned_q;
    logic          err_q;
    logic [31:0]   rdata_raw_q;

    logic          ready_q;
    logic          done_q;
    logic          err_out_q;
    logic [31:0]   rdata_q;
    logic [17:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    bmask_q;
    logic          wren_q;
    logic          rden_q;

    // Aligner sees the live request while idle and the captured request afterwards
    size_e         size_d;
    logic [1:0]    addr_lo_d;
    logic [31:0]   st_lanes;
    logic [3:0]    st_bmask;
    logic [31:0]   ld_data;
    logic          unused_addr_hi;

    assign size_d         = (state_q == StIdle) ? size_e'(i_size) : size_q;
    assign addr_lo_d      = (state_q == StIdle) ? i_addr[1:0] : addr_lo_q;
    assign unused_addr_hi = ^i_addr[31:19];

    lsu_sram_align u_align (
        .size_i     (size_d),
        .addr_lo_i  (addr_lo_d),
        .st_data_i  (i_wdata),
        .ld_word_i  (rdata_raw_q),
        .unsigned_i (unsigned_q),
        .st_lanes_o (st_lanes),
        .bmask_o    (st_bmask),
        .ld_data_o  (ld_data)
    );

`ifdef LSU_SRAM_TIMEOUT_EN
    logic [7:0] wait_cnt_q;
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES[0];
`endif

    // Request FSM; every CPU- and controller-facing output is a register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= StIdle;
            we_q        <= 1'b0;
            addr_lo_q   <= 2'b00;
            size_q      <= SzByte;
            unsigned_q  <= 1'b0;
            err_q       <= 1'b0;
            rdata_raw_q <= 32'd0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            err_out_q   <= 1'b0;
            rdata_q     <= 32'd0;
            addr_q      <= 18'd0;
            wdata_q     <= 32'd0;
            bmask_q     <= 4'd0;
            wren_q      <= 1'b0;
            rden_q      <= 1'b0;
`ifdef LSU_SRAM_TIMEOUT_EN
            wait_cnt_q  <= 8'd0;
`endif
        end else begin
            done_q    <= 1'b0;
            err_out_q <= 1'b0;
            rdata_q   <= 32'd0;
            wren_q    <= 1'b0;
            rden_q    <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (i_req) begin
                        we_q       <= i_we;
                        addr_lo_q  <= i_addr[1:0];
                        size_q     <= size_e'(i_size);
                        unsigned_q <= i_unsigned;
                        addr_q     <= {i_addr[SRAM_WORD_BITS+1:2], 1'b0};
                        wdata_q    <= st_lanes;
                        bmask_q    <= st_bmask;
                        ready_q    <= 1'b0;
                        if (is_misaligned(size_e'(i_size), i_addr[1:0])) begin
                            err_q   <= 1'b1;
                            state_q <= StResp;
                        end else begin
                            err_q   <= 1'b0;
                            wren_q  <= i_we;
                            rden_q  <= ~i_we;
                            state_q <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    state_q <= StWait;
`ifdef LSU_SRAM_TIMEOUT_EN
                    wait_cnt_q <= 8'd0;
`endif
                end
                StWait: begin
                    if (i_ACK) begin
                        rdata_raw_q <= i_RDATA;
                        state_q     <= StResp;
                    end
`ifdef LSU_SRAM_TIMEOUT_EN
                    else if (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= StResp;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
`endif
                end
                StResp: begin
                    done_q    <= 1'b1;
                    err_out_q <= err_q;
                    rdata_q   <= (we_q || err_q) ? 32'd0 : ld_data;
                    ready_q   <= 1'b1;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_ready = ready_q;
    assign o_done  = done_q;
    assign o_err   = err_out_q;
    assign o_rdata = rdata_q;
    assign o_ADDR  = addr_q;
    assign o_WDATA = wdata_q;
    assign o_BMASK = bmask_q;
    assign o_WREN  = wren_q;
    assign o_RDEN  = rden_q;

endmodule

// File: tb/tb_lsu_sram_bridge.sv
// tb/tb_lsu_sram_bridge.sv - self-checking bench for lsu_sram_bridge with a word-memory reference model
module tb_lsu_sram_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [17:0] s_ADDR;
    logic [31:0] s_WDATA;
    logic [3:0]  s_BMASK;
    logic        s_WREN;
    logic        s_RDEN;
    logic [31:0] s_RDATA;
    logic        s_ACK;

    int tests = 0;
    int fails = 0;
    logic [31:0] mem [int];
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    lsu_sram_bridge #(.TIMEOUT_CYCLES(16)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_req      (req),
        .i_we       (we),
        .i_addr     (addr),
        .i_wdata    (wdata),
        .i_size     (size),
        .i_unsigned (uns),
        .o_ready    (ready),
        .o_done     (done),
        .o_err      (err),
        .o_rdata    (rdata),
        .o_ADDR     (s_ADDR),
        .o_WDATA    (s_WDATA),
        .o_BMASK    (s_BMASK),
        .o_WREN     (s_WREN),
        .o_RDEN     (s_RDEN),
        .i_RDATA    (s_RDATA),
        .i_ACK      (s_ACK)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request, called and returning at a negedge. d = WAIT cycles before ACK, <0 = never.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [1:0] sz, input logic u,
                          input logic [31:0] wd, input int d, input string tag);
        int nb, off, key, sk, done_k, wr_n, rd_n, exp_k;
        logic mis, exp_err, d_err, ready_seen;
        logic [3:0] emask, s_mask;
        logic [31:0] elanes, eword, erd, m, v, s_wdata, d_rd;
        logic [17:0] s_addr;
        off = int'(a[1:0]);
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        mis = (sz == 2'd3) || ((off % nb) != 0);
        emask = 4'(((1 << nb) - 1) << off);
        for (int i = 0; i < 4; i++) elanes[8*i +: 8] = wd[8*(i % nb) +: 8];
        key = int'(a[18:2]);
        if (!mem.exists(key)) mem[key] = $urandom;
        eword = mem[key];
        m = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
        v = (eword >> (8*off)) & m;
        if (!u && v[8*nb-1]) v = v | ~m;
        erd = (w || mis) ? 32'd0 : v;
        exp_err = mis;
        if (mis) exp_k = 1;
        else if (d >= 0) exp_k = 3 + d;
        else begin
`ifdef LSU_SRAM_TIMEOUT_EN
            exp_k = 2 + 16;
            exp_err = 1'b1;
            erd = 32'd0;
`else
            exp_k = -1;
`endif
        end

        check({tag, "_ready_before"}, 32'(ready), 32'd1);
        req = 1'b1; we = w; addr = a; wdata = wd; size = sz; uns = u;
        sk = -1; done_k = -1; wr_n = 0; rd_n = 0;
        d_err = 1'b0; d_rd = 32'd0; ready_seen = 1'b0;
        s_addr = '0; s_mask = '0; s_wdata = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) begin
                done_k = k; d_err = err; d_rd = rdata; ready_seen = ready;
                break;
            end
            if (s_WREN || s_RDEN) begin
                wr_n += int'(s_WREN);
                rd_n += int'(s_RDEN);
                if (sk < 0) begin
                    sk = k; s_addr = s_ADDR; s_mask = s_BMASK; s_wdata = s_WDATA;
                end
            end
            s_ACK = (sk >= 0 && d >= 0 && k == sk + 1 + d);
            s_RDATA = s_ACK ? eword : $urandom;
            // Requests while busy must be ignored
            req = 1'($urandom_range(0, 1)); we = 1'($urandom); addr = $urandom;
            wdata = $urandom; size = 2'($urandom); uns = 1'($urandom);
        end
        s_ACK = 1'b0;
        req = 1'b0;

        if (w && !mis && d >= 0)
            for (int i = 0; i < 4; i++)
                if (emask[i]) mem[key][8*i +: 8] = elanes[8*i +: 8];

        check({tag, "_latency"}, 32'(done_k), 32'(exp_k));
        check({tag, "_wren_cnt"}, 32'(wr_n), 32'((w && !mis) ? 1 : 0));
        check({tag, "_rden_cnt"}, 32'(rd_n), 32'((!w && !mis) ? 1 : 0));
        if (done_k >= 0) begin
            check({tag, "_err"}, 32'(d_err), 32'(exp_err));
            check({tag, "_rdata"}, d_rd, erd);
            check({tag, "_ready_at_done"}, 32'(ready_seen), 32'd1);
        end
        if (sk >= 0) begin
            check({tag, "_addr"}, 32'(s_addr), 32'({a[18:2], 1'b0}));
            check({tag, "_bmask"}, 32'(s_mask), 32'(emask));
            if (w) check({tag, "_wdata"}, s_wdata, elanes);
        end
        last_rd = d_rd;
    endtask

    initial begin
        bit bad;
        logic [31:0] ra;
        reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; size = '0; uns = 1'b0;
        s_RDATA = '0; s_ACK = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_done", 32'(done), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_strobes", 32'({s_WREN, s_RDEN}), 32'd0);
        check("reset_addr", 32'(s_ADDR), 32'd0);
        check("reset_bmask", 32'(s_BMASK), 32'd0);
        reset = 1'b0;

        do_req(1'b1, 32'h0000_0100, 2'd2, 1'b0, 32'hDEAD_BEEF, 0, "st_word");
        do_req(1'b0, 32'h0000_0100, 2'd2, 1'b0, 32'h0, 3, "ld_word");
        check("ld_word_value", last_rd, 32'hDEAD_BEEF);
        do_req(1'b0, 32'h0000_0103, 2'd0, 1'b0, 32'h0, 1, "ld_byte_s");
        check("ld_byte_s_value", last_rd, 32'hFFFF_FFDE);
        do_req(1'b0, 32'h0000_0103, 2'd0, 1'b1, 32'h0, 2, "ld_byte_u");
        check("ld_byte_u_value", last_rd, 32'h0000_00DE);
        do_req(1'b1, 32'h0000_0103, 2'd0, 1'b0, 32'h0000_00AB, 0, "st_byte");
        mem[32'h40] = 32'h8001_1234;
        do_req(1'b0, 32'h0000_0102, 2'd1, 1'b0, 32'h0, 3, "ld_half_s");
        check("ld_half_s_value", last_rd, 32'hFFFF_8001);
        do_req(1'b0, 32'h0000_0101, 2'd1, 1'b0, 32'h0, 0, "ld_half_mis");
        do_req(1'b1, 32'h0000_0106, 2'd2, 1'b0, 32'h1234_5678, 0, "st_word_mis");
        do_req(1'b0, 32'h0000_0104, 2'd3, 1'b0, 32'h0, 0, "illegal_size");

        for (int i = 0; i < 40; i++) begin
            ra = ($urandom & 32'hFFF8_0000) | (32'h100 + 32'($urandom_range(0, 31)));
            do_req(1'($urandom), ra, 2'($urandom), 1'($urandom), $urandom,
                   $urandom_range(0, 4), $sformatf("rnd%0d", i));
        end

        // Reset while a load waits for ACK
        req = 1'b1; we = 1'b0; addr = 32'h104; size = 2'd2; uns = 1'b0;
        @(negedge clk); req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_strobes", 32'({s_WREN, s_RDEN}), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        s_ACK = 1'b1; s_RDATA = 32'hCAFE_F00D;
        @(negedge clk);
        s_ACK = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (done || !ready || s_WREN || s_RDEN) bad = 1'b1;
            @(negedge clk);
        end
        check("late_ack_ignored", 32'(bad), 32'd0);

        // Controller never acknowledges
        do_req(1'b0, 32'h0000_0108, 2'd2, 1'b0, 32'h0, -1, "noack");
`ifndef LSU_SRAM_TIMEOUT_EN
        check("noack_still_busy", 32'(ready), 32'd0);
`endif
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("final_ready", 32'(ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
